// File: rtl/cim_input_ctrl_if.sv
// rtl/cim_input_ctrl_if.sv - start/vector/crossbar handshake bundle for cim_input_ctrl
// master drives the request side, slave (the controller) drives the row stream and status.
interface cim_input_ctrl_if #(
   parameter int DATATYPE_SIZE = 8,
   parameter int INPUT_SIZE    = 5,
   parameter int XBAR_SIZE     = 256
);
   localparam int VERTICAL_TILES = (INPUT_SIZE + XBAR_SIZE - 1) / XBAR_SIZE;
   localparam int AW             = (XBAR_SIZE > 1) ? $clog2(XBAR_SIZE) : 1;

   logic                                     i_start_ctrl;
   logic [INPUT_SIZE*DATATYPE_SIZE-1:0]      i_data;
   logic                                     i_cim_done;
   logic                                     o_busy;
   logic                                     o_valid;
   logic [AW-1:0]                            o_addr;
   logic [VERTICAL_TILES*DATATYPE_SIZE-1:0]  o_data;
   logic                                     o_start_cim;
   logic                                     o_done;

   modport master (
      output i_start_ctrl, i_data, i_cim_done,
      input  o_busy, o_valid, o_addr, o_data, o_start_cim, o_done
   );

   modport slave (
      input  i_start_ctrl, i_data, i_cim_done,
      output o_busy, o_valid, o_addr, o_data, o_start_cim, o_done
   );
endinterface

// File: rtl/cim_input_ctrl.sv
// rtl/cim_input_ctrl.sv - streams a buffered input vector into crossbar tiles row by row, then activates compute
// CIM_CTRL_WAIT_DONE_EN: when defined, waits for i_cim_done before signalling o_done.
module cim_input_ctrl #(
   parameter int DATATYPE_SIZE = 8,
   parameter int INPUT_SIZE    = 5,
   parameter int XBAR_SIZE     = 256
) (
   input logic              clk,
   input logic              rst,
   cim_input_ctrl_if.slave  bus
);
   localparam int VERTICAL_TILES = (INPUT_SIZE + XBAR_SIZE - 1) / XBAR_SIZE;
   localparam int TRANSFER_LEN   = (INPUT_SIZE < XBAR_SIZE) ? INPUT_SIZE : XBAR_SIZE;
   localparam int AW             = (XBAR_SIZE > 1) ? $clog2(XBAR_SIZE) : 1;
   localparam int BW             = INPUT_SIZE * DATATYPE_SIZE;
   localparam int OW             = VERTICAL_TILES * DATATYPE_SIZE;

`ifdef CIM_CTRL_WAIT_DONE_EN
   typedef enum logic [1:0] {IDLE, TRANSFER, ACTIVATE, WAIT} state_t;
`else
   typedef enum logic [1:0] {IDLE, TRANSFER, ACTIVATE} state_t;
   logic unused_cim_done;
   assign unused_cim_done = bus.i_cim_done;
`endif

   state_t          state, state_n;
   logic [AW-1:0]   cnt, cnt_n;
   logic [BW-1:0]   buffer, buf_n;
   logic [OW-1:0]   data_n;
   logic            done_n;
   int              idx;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      buf_n   = buffer;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.i_start_ctrl) begin
               buf_n   = bus.i_data;
               cnt_n   = '0;
               state_n = TRANSFER;
            end
         end
         TRANSFER: begin
            if (cnt == AW'(TRANSFER_LEN - 1)) begin
               cnt_n   = '0;
               state_n = ACTIVATE;
            end else begin
               cnt_n = cnt + AW'(1);
            end
         end
         ACTIVATE: begin
`ifdef CIM_CTRL_WAIT_DONE_EN
            state_n = WAIT;
`else
            state_n = IDLE;
            done_n  = 1'b1;
`endif
         end
`ifdef CIM_CTRL_WAIT_DONE_EN
         WAIT: begin
            if (bus.i_cim_done) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
`endif
         default: state_n = IDLE;
      endcase

      // Outputs are built from the next-cycle state so every output is a plain register.
      data_n = '0;
      idx    = 0;
      if (state_n == TRANSFER) begin
         for (int t = 0; t < VERTICAL_TILES; t++) begin
            idx = t * XBAR_SIZE + int'(cnt_n);
            if (idx < INPUT_SIZE)
               data_n[t*DATATYPE_SIZE +: DATATYPE_SIZE] = buf_n[idx*DATATYPE_SIZE +: DATATYPE_SIZE];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         cnt             <= '0;
         buffer          <= '0;
         bus.o_busy      <= 1'b0;
         bus.o_valid     <= 1'b0;
         bus.o_addr      <= '0;
         bus.o_data      <= '0;
         bus.o_start_cim <= 1'b0;
         bus.o_done      <= 1'b0;
      end else begin
         state           <= state_n;
         cnt             <= cnt_n;
         buffer          <= buf_n;
         bus.o_busy      <= (state_n != IDLE);
         bus.o_valid     <= (state_n == TRANSFER);
         bus.o_addr      <= (state_n == TRANSFER) ? cnt_n : '0;
         bus.o_data      <= data_n;
         bus.o_start_cim <= (state_n == ACTIVATE);
         bus.o_done      <= done_n;
      end
   end
endmodule

// File: tb/tb_cim_input_ctrl.sv
// tb/tb_cim_input_ctrl.sv - scoreboard bench for cim_input_ctrl (two-tile and one-tile builds)
module tb_cim_input_ctrl;
   logic clk;
   logic rst;
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   logic [17:0] exp_q[$];
   logic [17:0] got;
   logic [17:0] exp_v;

   localparam logic [39:0] D_A = 40'h14_13_12_11_10;
   localparam logic [39:0] D_B = 40'hA4_A3_A2_A1_A0;

   cim_input_ctrl_if #(.DATATYPE_SIZE(8), .INPUT_SIZE(5), .XBAR_SIZE(4)) bus0 ();
   cim_input_ctrl_if #(.DATATYPE_SIZE(8), .INPUT_SIZE(4), .XBAR_SIZE(4)) bus1 ();

   cim_input_ctrl #(.DATATYPE_SIZE(8), .INPUT_SIZE(5), .XBAR_SIZE(4)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   cim_input_ctrl #(.DATATYPE_SIZE(8), .INPUT_SIZE(4), .XBAR_SIZE(4)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Tile 0 carries element a, tile 1 carries element 4+a (only element 4 exists).
   function automatic void push_rows(input logic [39:0] d);
      logic [7:0] t1;
      for (int a = 0; a < 4; a++) begin
         t1 = 8'h00;
         if (a + 4 < 5) t1 = d[(a+4)*8 +: 8];
         exp_q.push_back({2'(a), t1, d[a*8 +: 8]});
      end
   endfunction

   task automatic do_start(input logic [39:0] d);
      bus0.i_data       = d;
      bus0.i_start_ctrl = 1'b1;
      push_rows(d);
      tick();
      bus0.i_start_ctrl = 1'b0;
   endtask

   task automatic check_rows(input string name, input bit noise);
      for (int a = 0; a < 4; a++) begin
         total_cnt++;
         if ({bus0.o_valid, bus0.o_busy, bus0.o_start_cim, bus0.o_done} !== 4'b1100)
            $display("FAIL %s row%0d flags: got %b exp 1100", name, a,
                     {bus0.o_valid, bus0.o_busy, bus0.o_start_cim, bus0.o_done});
         else pass_cnt++;
         got = {bus0.o_addr, bus0.o_data};
         total_cnt++;
         if (exp_q.size() == 0) begin
            $display("FAIL %s row%0d: got %h exp <empty scoreboard>", name, a, got);
         end else begin
            exp_v = exp_q.pop_front();
            if (got !== exp_v) $display("FAIL %s row%0d: got %h exp %h", name, a, got, exp_v);
            else pass_cnt++;
         end
         if (noise && a == 1) begin
            bus0.i_start_ctrl = 1'b1;
            bus0.i_data       = '1;
            bus0.i_cim_done   = 1'b1;
         end
         if (noise && a == 3) begin
            bus0.i_start_ctrl = 1'b0;
            bus0.i_cim_done   = 1'b0;
         end
         tick();
      end
   endtask

   task automatic check_activate(input string name);
      total_cnt++;
      if ({bus0.o_valid, bus0.o_busy, bus0.o_start_cim, bus0.o_done} !== 4'b0110)
         $display("FAIL %s activate flags: got %b exp 0110", name,
                  {bus0.o_valid, bus0.o_busy, bus0.o_start_cim, bus0.o_done});
      else pass_cnt++;
      total_cnt++;
      if ({bus0.o_addr, bus0.o_data} !== 18'h0)
         $display("FAIL %s activate addr/data: got %h exp 0", name, {bus0.o_addr, bus0.o_data});
      else pass_cnt++;
   endtask

   task automatic finish_op(input string name, input bit b2b, input logic [39:0] nd);
`ifdef CIM_CTRL_WAIT_DONE_EN
      for (int k = 0; k < 3; k++) begin
         tick();
         total_cnt++;
         if ({bus0.o_busy, bus0.o_start_cim, bus0.o_done, bus0.o_valid} !== 4'b1000)
            $display("FAIL %s wait%0d flags: got %b exp 1000", name, k,
                     {bus0.o_busy, bus0.o_start_cim, bus0.o_done, bus0.o_valid});
         else pass_cnt++;
      end
      bus0.i_cim_done = 1'b1;
      tick();
      bus0.i_cim_done = 1'b0;
`else
      tick();
`endif
      total_cnt++;
      if ({bus0.o_busy, bus0.o_done, bus0.o_start_cim} !== 3'b010)
         $display("FAIL %s done flags: got %b exp 010", name,
                  {bus0.o_busy, bus0.o_done, bus0.o_start_cim});
      else pass_cnt++;
      if (b2b) begin
         do_start(nd);
         total_cnt++;
         if (bus0.o_done !== 1'b0) $display("FAIL %s done width: got %b exp 0", name, bus0.o_done);
         else pass_cnt++;
      end else begin
         tick();
         total_cnt++;
         if ({bus0.o_busy, bus0.o_done} !== 2'b00)
            $display("FAIL %s idle after done: got %b exp 00", name, {bus0.o_busy, bus0.o_done});
         else pass_cnt++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus0.i_start_ctrl = 1'b0; bus0.i_data = '0; bus0.i_cim_done = 1'b0;
      bus1.i_start_ctrl = 1'b0; bus1.i_data = '0; bus1.i_cim_done = 1'b0;
      tick();
      tick();
      total_cnt++;
      if ({bus0.o_busy, bus0.o_valid, bus0.o_start_cim, bus0.o_done, bus0.o_addr, bus0.o_data} !== 22'h0)
         $display("FAIL reset dut0: got %h exp 0",
                  {bus0.o_busy, bus0.o_valid, bus0.o_start_cim, bus0.o_done, bus0.o_addr, bus0.o_data});
      else pass_cnt++;
      total_cnt++;
      if ({bus1.o_busy, bus1.o_valid, bus1.o_start_cim, bus1.o_done, bus1.o_addr, bus1.o_data} !== 14'h0)
         $display("FAIL reset dut1: got %h exp 0",
                  {bus1.o_busy, bus1.o_valid, bus1.o_start_cim, bus1.o_done, bus1.o_addr, bus1.o_data});
      else pass_cnt++;
      rst = 1'b1;
   endtask

   task automatic test_back_to_back();
      do_start(D_A);
      check_rows("xfer_a", 1'b0);
      check_activate("xfer_a");
      finish_op("xfer_a", 1'b1, D_B);
      check_rows("b2b", 1'b0);
      check_activate("b2b");
      finish_op("b2b", 1'b0, '0);
   endtask

   task automatic test_reset_abort();
      do_start(D_A);
      tick();
      rst = 1'b0;
      #1;
      total_cnt++;
      if ({bus0.o_busy, bus0.o_valid, bus0.o_start_cim, bus0.o_done, bus0.o_addr, bus0.o_data} !== 22'h0)
         $display("FAIL abort async: got %h exp 0",
                  {bus0.o_busy, bus0.o_valid, bus0.o_start_cim, bus0.o_done, bus0.o_addr, bus0.o_data});
      else pass_cnt++;
      exp_q.delete();
      for (int k = 0; k < 3; k++) begin
         tick();
         total_cnt++;
         if ({bus0.o_start_cim, bus0.o_done, bus0.o_busy} !== 3'b000)
            $display("FAIL abort hold%0d: got %b exp 000", k, {bus0.o_start_cim, bus0.o_done, bus0.o_busy});
         else pass_cnt++;
      end
      rst = 1'b1;
      do_start(D_A);
      check_rows("after_rst", 1'b0);
      check_activate("after_rst");
      finish_op("after_rst", 1'b0, '0);
   endtask

   task automatic test_ignore();
      do_start(D_A);
      check_rows("ignore", 1'b1);
      check_activate("ignore");
      finish_op("ignore", 1'b0, '0);
   endtask

   task automatic test_one_tile();
      bus1.i_data       = 32'h13_12_11_10;
      bus1.i_start_ctrl = 1'b1;
      tick();
      bus1.i_start_ctrl = 1'b0;
      bus1.i_data       = '0;
      for (int a = 0; a < 4; a++) begin
         total_cnt++;
         if ({bus1.o_valid, bus1.o_addr, bus1.o_data} !== {1'b1, 2'(a), 8'(8'h10 + a)})
            $display("FAIL one_tile row%0d: got %h exp %h", a, {bus1.o_valid, bus1.o_addr, bus1.o_data},
                     {1'b1, 2'(a), 8'(8'h10 + a)});
         else pass_cnt++;
         tick();
      end
      total_cnt++;
      if ({bus1.o_start_cim, bus1.o_valid} !== 2'b10)
         $display("FAIL one_tile activate: got %b exp 10", {bus1.o_start_cim, bus1.o_valid});
      else pass_cnt++;
`ifdef CIM_CTRL_WAIT_DONE_EN
      tick();
      bus1.i_cim_done = 1'b1;
      tick();
      bus1.i_cim_done = 1'b0;
`else
      tick();
`endif
      total_cnt++;
      if ({bus1.o_done, bus1.o_busy} !== 2'b10)
         $display("FAIL one_tile done: got %b exp 10", {bus1.o_done, bus1.o_busy});
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_reset_abort();
      test_ignore();
      test_one_tile();
      total_cnt++;
      if (exp_q.size() != 0) $display("FAIL scoreboard drain: got %0d exp 0", exp_q.size());
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/cim_input_ctrl.md
CIM_INPUT_CTRL -- requirements
Module: cim_input_ctrl

Interface
REQ-001 SHALL have parameter DATATYPE_SIZE, default 8, bits per input element.
REQ-002 SHALL have parameter INPUT_SIZE, default 5, number of input vector elements.
REQ-003 SHALL have parameter XBAR_SIZE, default 256, crossbar rows per tile.
REQ-004 SHALL derive VERTICAL_TILES = ceil(INPUT_SIZE/XBAR_SIZE), TRANSFER_LEN = min(INPUT_SIZE, XBAR_SIZE), AW = max(1, clog2(XBAR_SIZE)); none overridable.
REQ-005 SHALL have clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have i_start_ctrl, input, 1, start request.
REQ-008 SHALL have i_data, input, INPUT_SIZE*DATATYPE_SIZE, flat input vector, element k at bits [k*DATATYPE_SIZE +: DATATYPE_SIZE].
REQ-009 SHALL have i_cim_done, input, 1, crossbar compute-complete pulse.
REQ-010 SHALL have o_busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have o_valid, output, 1, o_data/o_addr qualifier.
REQ-012 SHALL have o_addr, output, AW, crossbar row address.
REQ-013 SHALL have o_data, output, VERTICAL_TILES*DATATYPE_SIZE, one element per tile, tile t at [t*DATATYPE_SIZE +: DATATYPE_SIZE].
REQ-014 SHALL have o_start_cim, output, 1, one-cycle crossbar activate pulse.
REQ-015 SHALL have o_done, output, 1, one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, TRANSFER, ACTIVATE, WAIT with all outputs registered.
REQ-017 IDLE: i_start_ctrl=1 SHALL capture i_data into an internal buffer, clear row counter, go to TRANSFER next cycle.
REQ-018 i_start_ctrl while not IDLE SHALL be ignored; i_data changes after capture SHALL not affect output.
REQ-019 TRANSFER: for counter a = 0..TRANSFER_LEN-1, one row per cycle, o_valid=1, o_addr=a, tile t data = buffered element t*XBAR_SIZE+a.
REQ-020 Element index >= INPUT_SIZE SHALL be driven as zero (pad of last tile).
REQ-021 After row TRANSFER_LEN-1, counter SHALL wrap to 0 and FSM go to ACTIVATE; no stall, no gaps.
REQ-022 ACTIVATE: o_start_cim=1 for exactly one cycle, o_valid=0; next state per REQ-030.
REQ-023 WAIT: hold until i_cim_done=1, then IDLE with o_done=1 in the same cycle the FSM re-enters IDLE.
REQ-024 i_cim_done outside WAIT SHALL be ignored.
REQ-025 Latency: start accepted at cycle 0 -> first o_valid cycle 1 -> o_start_cim cycle TRANSFER_LEN+1.
REQ-026 Back-to-back: a start presented in the cycle o_done is high (IDLE) SHALL be accepted.
REQ-027 o_data/o_addr SHALL be zero whenever o_valid=0.

Reset
REQ-028 rst=0 SHALL asynchronously force IDLE, counter 0, buffer 0, all outputs 0; abort any transfer with no o_start_cim or o_done.
REQ-029 After rst release, first start SHALL be accepted on the first rising edge with rst=1.

Configuration
REQ-030 Macro CIM_CTRL_WAIT_DONE_EN: defined -> ACTIVATE goes to WAIT per REQ-023; undefined -> ACTIVATE goes directly to IDLE with o_done=1 on that transition, WAIT state and i_cim_done logic absent (port kept, unused).

Verification (DATATYPE_SIZE=8, INPUT_SIZE=5, XBAR_SIZE=4 -> 2 tiles, TRANSFER_LEN=4, macro defined unless stated)
REQ-031 Start with elements 0x10..0x14 -> addr0 {t0=0x10,t1=0x14}, addr1 {0x11,0x00}, addr2 {0x12,0x00}, addr3 {0x13,0x00}, o_start_cim cycle 5.
REQ-032 i_cim_done 3 cycles after o_start_cim -> o_busy high throughout, o_done one cycle, then IDLE; second start same cycle accepted.
REQ-033 rst=0 asserted at second TRANSFER row -> outputs 0 immediately, no o_start_cim; fresh start then produces full REQ-031 sequence.
REQ-034 i_start_ctrl and i_data=0xFF.. changed mid-TRANSFER -> ignored; sequence identical to REQ-031.
REQ-035 Macro undefined -> o_done one cycle after o_start_cim, i_cim_done has no effect.
REQ-036 INPUT_SIZE=4, XBAR_SIZE=4 -> one tile, 4 rows 0x10..0x13, no padding.
